// File: rtl/coeff_bank_ctrl_pkg.sv
// eq_coeff_pkg: shared defaults, coefficient type and commit FSM states for the multi-band coefficient store
package eq_coeff_pkg;
    localparam int COEFF_W_D = 16;
    localparam int NUM_TAPS_D = 64;
    localparam int NUM_BANDS_D = 8;
    typedef logic signed [COEFF_W_D-1:0] coeff_t;
    typedef enum logic {IDLE, PENDING} commit_st_t;
endpackage

// File: rtl/coeff_bank_ctrl_if.sv
// coeff_bank_ctrl_if: host write handshake, commit control and parallel read bus of the coefficient store
//   master: host side (drives wr_*, commit_req, rd_addr)
//   slave : store side (drives wr_ready, wr_err, commit_pending, commit_done, coeff_out)
interface coeff_bank_ctrl_if #(
    parameter int COEFF_W = 16,
    parameter int ADDR_W = 6,
    parameter int BAND_W = 3,
    parameter int NUM_BANDS = 8
);
    logic wr_valid;
    logic wr_ready;
    logic [BAND_W-1:0] wr_band;
    logic [ADDR_W-1:0] wr_addr;
    logic [COEFF_W-1:0] wr_data;
    logic wr_err;
    logic commit_req;
    logic commit_pending;
    logic commit_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [NUM_BANDS*COEFF_W-1:0] coeff_out;
    modport master (
        output wr_valid, wr_band, wr_addr, wr_data, commit_req, rd_addr,
        input wr_ready, wr_err, commit_pending, commit_done, coeff_out
    );
    modport slave (
        input wr_valid, wr_band, wr_addr, wr_data, commit_req, rd_addr,
        output wr_ready, wr_err, commit_pending, commit_done, coeff_out
    );
endinterface

// File: rtl/coeff_bank_ctrl_store.sv
// coeff_band_store: one band's staging/active coefficient arrays with write port, bulk commit copy and registered read
//   clk, rst : clock, async active-high reset
//   en       : datapath enable (gates write, copy, read register)
//   we/addr/data : qualified in-range staging write
//   copy     : staging -> active transfer this edge
//   rd_addr/rd_data : registered read of active, zero when rd_addr is past the last tap
module coeff_band_store #(
    parameter int COEFF_W = 16,
    parameter int NUM_TAPS = 64,
    parameter int SYMMETRIC = 0,
    parameter int ADDR_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [COEFF_W-1:0] data,
    input  logic copy,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COEFF_W-1:0] rd_data
);
    logic [COEFF_W-1:0] stg [NUM_TAPS];
    logic [COEFF_W-1:0] act [NUM_TAPS];
    logic [ADDR_W-1:0] mir;
    assign mir = ADDR_W'(NUM_TAPS - 1) - addr;
    // For odd tap counts the centre tap mirrors onto itself; the double write carries the same value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                stg[t] <= '0;
                act[t] <= '0;
            end
            rd_data <= '0;
        end else if (en) begin
            if (we) stg[addr] <= data;
            if (we && SYMMETRIC != 0) stg[mir] <= data;
            if (copy)
                for (int t = 0; t < NUM_TAPS; t++) act[t] <= stg[t];
            rd_data <= (int'(rd_addr) < NUM_TAPS) ? act[rd_addr] : '0;
        end
    end
endmodule

// File: rtl/coeff_bank_ctrl.sv
// coeff_bank_ctrl: multi-band staged coefficient store with frame-aligned atomic commit
//   clk, rst   : clock, async active-high reset
//   clk_enable : datapath enable
//   frame_sync : start-of-sample pulse; commits land only here
//   bus        : slave side of coeff_bank_ctrl_if (writes, commit, parallel read)
module coeff_bank_ctrl
    import eq_coeff_pkg::*;
#(
    parameter int COEFF_W = COEFF_W_D,
    parameter int NUM_TAPS = NUM_TAPS_D,
    parameter int NUM_BANDS = NUM_BANDS_D,
    parameter int SYMMETRIC = 0,
    parameter int ADDR_W = $clog2(NUM_TAPS),
    parameter int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input logic clk,
    input logic rst,
    input logic clk_enable,
    input logic frame_sync,
    coeff_bank_ctrl_if.slave bus
);
    commit_st_t state, state_nx;
    logic accept, in_range, copy, wr_err, commit_done;
    logic [NUM_BANDS*COEFF_W-1:0] lanes;
    assign accept = bus.wr_valid && bus.wr_ready && clk_enable;
    assign in_range = (int'(bus.wr_band) < NUM_BANDS) && (int'(bus.wr_addr) < NUM_TAPS);
    // Only a request already registered as pending can copy, so a frame_sync
    // coinciding with the first commit_req cycle never tears a frame.
    assign copy = (state == PENDING) && frame_sync && clk_enable;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (bus.commit_req ? PENDING : IDLE) : (copy ? IDLE : PENDING);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wr_err <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            state <= state_nx;
            wr_err <= accept && !in_range;
            commit_done <= copy;
        end
    end
    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        coeff_band_store #(
            .COEFF_W(COEFF_W), .NUM_TAPS(NUM_TAPS), .SYMMETRIC(SYMMETRIC), .ADDR_W(ADDR_W)
        ) u_store (
            .clk(clk),
            .rst(rst),
            .en(clk_enable),
            .we(accept && in_range && bus.wr_band == BAND_W'(b)),
            .addr(bus.wr_addr),
            .data(bus.wr_data),
            .copy(copy),
            .rd_addr(bus.rd_addr),
            .rd_data(lanes[b*COEFF_W +: COEFF_W])
        );
    end
    assign bus.wr_ready = (state == IDLE);
    assign bus.commit_pending = (state == PENDING);
    assign bus.wr_err = wr_err;
    assign bus.commit_done = commit_done;
    assign bus.coeff_out = lanes;
endmodule

// File: tb/tb_coeff_bank_ctrl.sv
// tb_coeff_bank_ctrl: directed self-checking bench for coeff_bank_ctrl (default, symmetric and 50-tap/wide-band variants)
module tb_coeff_bank_ctrl;
    logic clk = 1'b0;
    logic rst, clk_enable, frame_sync;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    coeff_bank_ctrl_if #(.COEFF_W(16), .ADDR_W(6), .BAND_W(3), .NUM_BANDS(8)) a_if ();
    coeff_bank_ctrl_if #(.COEFF_W(16), .ADDR_W(6), .BAND_W(3), .NUM_BANDS(8)) s_if ();
    coeff_bank_ctrl_if #(.COEFF_W(16), .ADDR_W(6), .BAND_W(4), .NUM_BANDS(8)) e_if ();

    coeff_bank_ctrl #(.COEFF_W(16), .NUM_TAPS(64), .NUM_BANDS(8), .SYMMETRIC(0)) dut_a (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .frame_sync(frame_sync), .bus(a_if));
    coeff_bank_ctrl #(.COEFF_W(16), .NUM_TAPS(64), .NUM_BANDS(8), .SYMMETRIC(1)) dut_s (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .frame_sync(frame_sync), .bus(s_if));
    coeff_bank_ctrl #(.COEFF_W(16), .NUM_TAPS(50), .NUM_BANDS(8), .SYMMETRIC(0), .BAND_W(4)) dut_e (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .frame_sync(frame_sync), .bus(e_if));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clk_enable = 1'b1; frame_sync = 1'b0;
        a_if.wr_valid = 0; a_if.wr_band = 0; a_if.wr_addr = 0; a_if.wr_data = 0; a_if.commit_req = 0; a_if.rd_addr = 6'd5;
        s_if.wr_valid = 0; s_if.wr_band = 0; s_if.wr_addr = 0; s_if.wr_data = 0; s_if.commit_req = 0; s_if.rd_addr = 0;
        e_if.wr_valid = 0; e_if.wr_band = 0; e_if.wr_addr = 0; e_if.wr_data = 0; e_if.commit_req = 0; e_if.rd_addr = 0;
        tick();
        chk("rst_ready", 128'(a_if.wr_ready), 128'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("reset_coeff", a_if.coeff_out, 128'd0);
        chk("reset_ready", 128'(a_if.wr_ready), 128'd1);
        chk("reset_pending", 128'(a_if.commit_pending), 128'd0);
        // band 2 tap 5, band 7 tap 63, then commit
        a_if.wr_valid = 1; a_if.wr_band = 3'd2; a_if.wr_addr = 6'd5; a_if.wr_data = 16'h7FFF;
        tick();
        a_if.wr_band = 3'd7; a_if.wr_addr = 6'd63; a_if.wr_data = 16'h8001;
        tick();
        a_if.wr_valid = 0; a_if.commit_req = 1;
        tick();
        a_if.commit_req = 0;
        chk("pend_set", 128'(a_if.commit_pending), 128'd1);
        chk("pend_ready", 128'(a_if.wr_ready), 128'd0);
        // write while pending must be ignored
        a_if.wr_valid = 1; a_if.wr_band = 3'd0; a_if.wr_addr = 6'd0; a_if.wr_data = 16'h5555;
        repeat (9) tick();
        chk("pend_hold", 128'(a_if.commit_pending), 128'd1);
        chk("pend_nodone", 128'(a_if.commit_done), 128'd0);
        chk("pend_old", a_if.coeff_out, 128'd0);
        a_if.wr_valid = 0; frame_sync = 1; a_if.rd_addr = 6'd5;
        tick();
        frame_sync = 0;
        chk("done_pulse", 128'(a_if.commit_done), 128'd1);
        chk("done_clear", 128'(a_if.commit_pending), 128'd0);
        chk("copy_cycle_old", a_if.coeff_out, 128'd0);
        tick();
        chk("done_one", 128'(a_if.commit_done), 128'd0);
        chk("rd5_new", a_if.coeff_out, 128'h7FFF << 32);
        a_if.rd_addr = 6'd0;
        tick();
        chk("rd0_frozen", a_if.coeff_out, 128'd0);
        a_if.rd_addr = 6'd63;
        tick();
        chk("rd63", a_if.coeff_out, 128'h8001 << 112);
        // clk_enable low: no write, read register holds
        clk_enable = 0; a_if.rd_addr = 6'd5;
        a_if.wr_valid = 1; a_if.wr_band = 3'd1; a_if.wr_addr = 6'd1; a_if.wr_data = 16'h1111;
        tick();
        chk("en_hold", a_if.coeff_out, 128'h8001 << 112);
        clk_enable = 1; a_if.wr_valid = 0;
        tick();
        chk("en_resume", a_if.coeff_out, 128'h7FFF << 32);
        // staged write without commit is invisible across frames
        a_if.wr_valid = 1; a_if.wr_band = 3'd3; a_if.wr_addr = 6'd5; a_if.wr_data = 16'h0ABC;
        tick();
        a_if.wr_valid = 0;
        repeat (3) begin
            frame_sync = 1; tick(); frame_sync = 0; tick();
        end
        chk("nocommit_out", a_if.coeff_out, 128'h7FFF << 32);
        chk("nocommit_pend", 128'(a_if.commit_pending), 128'd0);
        // frame_sync coinciding with first commit_req cycle does not copy
        a_if.commit_req = 1; frame_sync = 1;
        tick();
        a_if.commit_req = 0; frame_sync = 0;
        chk("same_pend", 128'(a_if.commit_pending), 128'd1);
        chk("same_nodone", 128'(a_if.commit_done), 128'd0);
        tick();
        frame_sync = 1;
        tick();
        frame_sync = 0;
        chk("second_done", 128'(a_if.commit_done), 128'd1);
        tick();
        chk("second_rd5", a_if.coeff_out, (128'h0ABC << 48) | (128'h7FFF << 32));
        a_if.rd_addr = 6'd1;
        tick();
        chk("en_drop", a_if.coeff_out, 128'd0);
        // reset in the middle of a pending commit
        a_if.rd_addr = 6'd5; a_if.commit_req = 1;
        tick();
        a_if.commit_req = 0;
        chk("rst_mid_pend", 128'(a_if.commit_pending), 128'd1);
        rst = 1;
        #2;
        chk("rst_async_pend", 128'(a_if.commit_pending), 128'd0);
        chk("rst_async_out", a_if.coeff_out, 128'd0);
        tick();
        rst = 0; frame_sync = 1;
        tick();
        frame_sync = 0;
        chk("rst_nodone", 128'(a_if.commit_done), 128'd0);
        tick();
        chk("rst_nodone2", 128'(a_if.commit_done), 128'd0);
        chk("rst_cleared", a_if.coeff_out, 128'd0);
        // symmetric mirror and range errors
        s_if.wr_valid = 1; s_if.wr_band = 3'd0; s_if.wr_addr = 6'd3; s_if.wr_data = 16'h1234;
        e_if.wr_valid = 1; e_if.wr_band = 4'd0; e_if.wr_addr = 6'd55; e_if.wr_data = 16'h7777;
        tick();
        chk("err_addr", 128'(e_if.wr_err), 128'd1);
        s_if.wr_valid = 0;
        e_if.wr_band = 4'd8; e_if.wr_addr = 6'd1; e_if.wr_data = 16'h6666;
        tick();
        chk("err_band", 128'(e_if.wr_err), 128'd1);
        e_if.wr_band = 4'd0; e_if.wr_addr = 6'd49; e_if.wr_data = 16'h4321;
        tick();
        chk("err_ok", 128'(e_if.wr_err), 128'd0);
        chk("err_s_none", 128'(s_if.wr_err), 128'd0);
        e_if.wr_valid = 0; s_if.commit_req = 1; e_if.commit_req = 1;
        tick();
        s_if.commit_req = 0; e_if.commit_req = 0; frame_sync = 1;
        tick();
        frame_sync = 0;
        chk("s_done", 128'(s_if.commit_done), 128'd1);
        s_if.rd_addr = 6'd3; e_if.rd_addr = 6'd49;
        tick();
        chk("sym_tap3", s_if.coeff_out, 128'h1234);
        chk("e_tap49", e_if.coeff_out, 128'h4321);
        s_if.rd_addr = 6'd60; e_if.rd_addr = 6'd55;
        tick();
        chk("sym_tap60", s_if.coeff_out, 128'h1234);
        chk("e_rd_oob", e_if.coeff_out, 128'd0);
        s_if.rd_addr = 6'd4; e_if.rd_addr = 6'd1;
        tick();
        chk("sym_tap4", s_if.coeff_out, 128'd0);
        chk("e_band8_drop", e_if.coeff_out, 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
